// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the fetch/data memory port arbiter: FSM states and grant owner.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    typedef enum logic {
        GNT_IF = 1'b0,
        GNT_DM = 1'b1
    } owner_t;

    // Bits needed to hold 0..max_val, never less than one.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/mem_arb_priority.sv
// Data-over-fetch grant select with a starvation cap on consecutive data grants.
// Combinational grant; counter advances only on grants issued while fetch waits.
module mem_arb_priority
    import mem_port_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic   clock,
    input  logic   reset,
    input  logic   arb_en,
    input  logic   if_req,
    input  logic   dm_req,
    output logic   grant_vld,
    output owner_t grant_owner
);

    localparam int CNT_W = cnt_width(STARVE_LIMIT);

    logic [CNT_W-1:0] starve_cnt;
    logic             starved;

    assign starved     = (starve_cnt == CNT_W'(STARVE_LIMIT));
    assign grant_vld   = arb_en & (if_req | dm_req);
    assign grant_owner = (dm_req && !(if_req && starved)) ? GNT_DM : GNT_IF;

    // Counts data grants that overtook a waiting fetch; any gap in if_req resets it.
    always_ff @(posedge clock) begin
        if (reset) begin
            starve_cnt <= '0;
        end else if (!if_req) begin
            starve_cnt <= '0;
        end else if (grant_vld) begin
            if (grant_owner == GNT_DM) begin
                starve_cnt <= starve_cnt + CNT_W'(1);
            end else begin
                starve_cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency single-port memory between fetch and the data stage.
// Req-to-ready: 1+MEM_LATENCY cycles for reads, 2 for writes; requesters stall until ready.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int MEM_LATENCY  = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    output logic                  if_ready,
    output logic [DATA_WIDTH-1:0] if_rdata,
    input  logic                  dm_req,
    input  logic                  dm_we,
    input  logic                  dm_is_byte,
    input  logic [ADDR_WIDTH-1:0] dm_addr,
    input  logic [DATA_WIDTH-1:0] dm_wdata,
    output logic                  dm_ready,
    output logic [DATA_WIDTH-1:0] dm_rdata,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic                  mem_byte,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  stall_if,
    output logic                  stall_dm
);

    localparam int LAT_W = cnt_width(MEM_LATENCY - 1);

    state_t                state, state_nxt;
    owner_t                owner_q;
    owner_t                grant_owner;
    logic                  grant_vld;
    logic                  grant;
    logic [LAT_W-1:0]      lat_cnt;
    logic                  issue_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic                  we_q;
    logic                  byte_q;
    logic [DATA_WIDTH-1:0] if_rdata_q;
    logic [DATA_WIDTH-1:0] dm_rdata_q;

    mem_arb_priority #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_priority (
        .clock       (clock),
        .reset       (reset),
        .arb_en      (state == ST_IDLE),
        .if_req      (if_req),
        .dm_req      (dm_req),
        .grant_vld   (grant_vld),
        .grant_owner (grant_owner)
    );

    assign grant = (state == ST_IDLE) && grant_vld;

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (grant_vld) state_nxt = ST_BUSY;
            ST_BUSY: if (lat_cnt == '0) state_nxt = ST_RESP;
            ST_RESP: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Writes finish after the single issue cycle; reads wait out the memory latency.
    always_ff @(posedge clock) begin
        if (reset) begin
            owner_q    <= GNT_IF;
            lat_cnt    <= '0;
            issue_q    <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            we_q       <= 1'b0;
            byte_q     <= 1'b0;
            if_rdata_q <= '0;
            dm_rdata_q <= '0;
        end else begin
            issue_q <= grant;
            if (grant) begin
                owner_q <= grant_owner;
                if (grant_owner == GNT_DM) begin
                    addr_q  <= dm_addr;
                    wdata_q <= dm_wdata;
                    we_q    <= dm_we;
                    byte_q  <= dm_is_byte;
                    lat_cnt <= dm_we ? '0 : LAT_W'(MEM_LATENCY - 1);
                end else begin
                    addr_q  <= if_addr;
                    wdata_q <= '0;
                    we_q    <= 1'b0;
                    byte_q  <= 1'b0;
                    lat_cnt <= LAT_W'(MEM_LATENCY - 1);
                end
            end else if (state == ST_BUSY) begin
                if (lat_cnt != '0) begin
                    lat_cnt <= lat_cnt - LAT_W'(1);
                end else if (!we_q) begin
                    if (owner_q == GNT_IF) begin
                        if_rdata_q <= mem_rdata;
                    end else begin
                        dm_rdata_q <= mem_rdata;
                    end
                end
            end
        end
    end

    assign mem_en    = issue_q;
    assign mem_we    = we_q;
    assign mem_byte  = byte_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

    assign if_ready  = (state == ST_RESP) && (owner_q == GNT_IF);
    assign dm_ready  = (state == ST_RESP) && (owner_q == GNT_DM);
    assign if_rdata  = if_rdata_q;
    assign dm_rdata  = dm_rdata_q;

    assign stall_if  = if_req & ~if_ready;
    assign stall_dm  = dm_req & ~dm_ready;

endmodule
